// File: rtl/fitbit_display_scheduler.sv
// fitbit_display_scheduler: rotates four step metrics onto a scanned 4-digit BCD display
module fitbit_display_scheduler #(
  parameter int MODE_SECS = 3,
  parameter int VAL_W = 14
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick_1hz,
  input  logic             tick_scan,
  input  logic             hold,
  input  logic [VAL_W-1:0] metric0,
  input  logic [VAL_W-1:0] metric1,
  input  logic [VAL_W-1:0] metric2,
  input  logic [VAL_W-1:0] metric3,
  output logic [1:0]       mode,
  output logic             busy,
  output logic [3:0]       an,
  output logic [3:0]       bcd_digit,
  output logic             dp
);
  localparam int SW = MODE_SECS > 1 ? $clog2(MODE_SECS) : 1;
  localparam int CW = $clog2(VAL_W + 1);
  typedef enum logic [1:0] {IDLE, CAPTURE, CONVERT, COMMIT} state_t;
  state_t           state;
  logic [SW-1:0]    sec_cnt;
  logic             start, pending, scan_en, adv, trig, blank;
  logic [1:0]       idx;
  logic [CW-1:0]    cnt;
  logic [VAL_W-1:0] sh, raw;
  logic [15:0]      acc, adj, disp;
  assign adv  = tick_1hz & ~hold & (sec_cnt == SW'(MODE_SECS - 1));
  assign trig = start | tick_1hz;
  assign busy = state != IDLE;
  assign raw  = mode == 2'd0 ? metric0 : mode == 2'd1 ? metric1 : mode == 2'd2 ? metric2 : metric3;
  // a digit is blank when it and every digit above it are zero; digit 0 always shows
  assign blank     = idx != 2'd0 && (disp >> {idx, 2'b00}) == 16'd0;
  assign an        = scan_en && !blank ? ~(4'b0001 << idx) : 4'b1111;
  assign bcd_digit = scan_en && !blank ? disp[{idx, 2'b00} +: 4] : 4'hF;
  assign dp        = !(scan_en && !blank && idx == 2'd1 && mode == 2'd1);
  // shift-add-3 correction applied to every BCD nibble before each shift
  always_comb begin
    adj = acc;
    for (int k = 0; k < 4; k++) adj[4*k +: 4] = acc[4*k +: 4] >= 4'd5 ? acc[4*k +: 4] + 4'd3 : acc[4*k +: 4];
  end
  // metric rotation; start requests one conversion right after reset releases
  always_ff @(posedge clk) begin
    if (rst) begin
      mode    <= 2'd0;
      sec_cnt <= '0;
      start   <= 1'b1;
    end else begin
      start <= 1'b0;
      if (tick_1hz && !hold) begin
        sec_cnt <= adv ? '0 : sec_cnt + 1'b1;
        mode    <= mode + 2'(adv);
      end
    end
  end
  // conversion FSM; triggers arriving while busy coalesce into one pending request
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      pending <= 1'b0;
      cnt     <= '0;
      sh      <= '0;
      acc     <= '0;
      disp    <= '0;
    end else begin
      if (trig) pending <= 1'b1;
      case (state)
        IDLE: if (trig || pending) begin
          state   <= CAPTURE;
          pending <= 1'b0;
        end
        CAPTURE: begin
          sh    <= raw > VAL_W'(9999) ? VAL_W'(9999) : raw;
          acc   <= '0;
          cnt   <= '0;
          state <= CONVERT;
        end
        CONVERT: begin
          acc   <= {adj[14:0], sh[VAL_W-1]};
          sh    <= sh << 1;
          cnt   <= cnt + 1'b1;
          state <= cnt == CW'(VAL_W - 1) ? COMMIT : CONVERT;
        end
        COMMIT: begin
          disp  <= acc;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
  // digit scan; the first tick after reset only enables the anodes on digit 0
  always_ff @(posedge clk) begin
    if (rst) begin
      idx     <= 2'd0;
      scan_en <= 1'b0;
    end else if (tick_scan) begin
      scan_en <= 1'b1;
      idx     <= idx + 2'(scan_en);
    end
  end
endmodule

// File: tb/tb_fitbit_display_scheduler.sv
// tb_fitbit_display_scheduler: directed checks of rotation, BCD conversion, blanking and scan
module tb_fitbit_display_scheduler;
  logic clk = 1'b0, rst = 1'b1, tick_1hz = 1'b0, tick_scan = 1'b0, hold = 1'b0;
  logic [13:0] metric0 = 14'd1234, metric1 = 14'd57, metric2 = 14'd321, metric3 = 14'd4000;
  logic [1:0] mode;
  logic busy, dp;
  logic [3:0] an, bcd_digit;
  int checks = 0, errs = 0;

  fitbit_display_scheduler dut (
    .clk(clk), .rst(rst), .tick_1hz(tick_1hz), .tick_scan(tick_scan), .hold(hold),
    .metric0(metric0), .metric1(metric1), .metric2(metric2), .metric3(metric3),
    .mode(mode), .busy(busy), .an(an), .bcd_digit(bcd_digit), .dp(dp)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_1hz;
    tick_1hz = 1'b1;
    cyc(1);
    tick_1hz = 1'b0;
  endtask

  // expected digits, nibble 4'hF marks a blanked digit
  function automatic logic [15:0] exp_disp(input int v);
    int c;
    logic [15:0] r;
    bit lead;
    c = v > 9999 ? 9999 : v;
    r = {4'(c / 1000), 4'((c / 100) % 10), 4'((c / 10) % 10), 4'(c % 10)};
    lead = 1'b1;
    for (int i = 3; i > 0; i--)
      if (lead && r[4*i +: 4] == 4'd0) r[4*i +: 4] = 4'hF;
      else lead = 1'b0;
    return r;
  endfunction

  task automatic scan4(input logic [15:0] e, input logic dp1, input string nm);
    logic [3:0] ea;
    logic ed;
    for (int i = 0; i < 4; i++) begin
      tick_scan = 1'b1;
      cyc(1);
      tick_scan = 1'b0;
      ea = e[4*i +: 4] == 4'hF ? 4'hF : ~(4'b0001 << i);
      ed = i == 1 ? dp1 : 1'b1;
      checks++;
      if (an !== ea || bcd_digit !== e[4*i +: 4] || dp !== ed) begin
        errs++;
        $display("FAIL %s idx%0d: got an=%b bcd=%h dp=%b, want an=%b bcd=%h dp=%b", nm, i, an, bcd_digit, dp, ea, e[4*i +: 4], ed);
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    cyc(2);
    checks++; if (busy !== 1'b0) begin errs++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (mode !== 2'd0) begin errs++; $display("FAIL reset_mode: got %0d want 0", mode); end
    checks++; if (an !== 4'b1111) begin errs++; $display("FAIL reset_an: got %b want 1111", an); end
    checks++; if (bcd_digit !== 4'hF) begin errs++; $display("FAIL reset_bcd: got %h want f", bcd_digit); end
    checks++; if (dp !== 1'b1) begin errs++; $display("FAIL reset_dp: got %b want 1", dp); end
  endtask

  task automatic test_first_conversion;
    int n;
    n = 0;
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      if (busy) n++;
    end
    checks++; if (n !== 16) begin errs++; $display("FAIL busy_len: got %0d want 16", n); end
    checks++; if (mode !== 2'd0) begin errs++; $display("FAIL t1_mode: got %0d want 0", mode); end
    scan4(exp_disp(1234), 1'b1, "t1_1234");
  endtask

  task automatic test_blank_clamp;
    int vals[6] = '{7, 0, 1005, 12000, 10000, 9999};
    hold = 1'b1;
    foreach (vals[j]) begin
      metric0 = 14'(vals[j]);
      pulse_1hz;
      cyc(17);
      scan4(exp_disp(vals[j]), 1'b1, $sformatf("val_%0d", vals[j]));
    end
  endtask

  task automatic test_rotation;
    logic [1:0] em;
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
    hold = 1'b0;
    metric0 = 14'd1234;
    cyc(20);
    for (int t = 1; t <= 12; t++) begin
      pulse_1hz;
      em = 2'((t / 3) % 4);
      checks++; if (mode !== em) begin errs++; $display("FAIL rot_mode t%0d: got %0d want %0d", t, mode, em); end
      cyc(17);
      if (t == 3) scan4(exp_disp(57), 1'b0, "rot_m1");
      if (t == 6) scan4(exp_disp(321), 1'b1, "rot_m2");
      if (t == 9) scan4(exp_disp(4000), 1'b1, "rot_m3");
      if (t == 12) scan4(exp_disp(1234), 1'b1, "rot_m0");
    end
  endtask

  task automatic test_hold;
    int v;
    hold = 1'b1;
    for (int t = 0; t < 10; t++) begin
      v = 104 * t + 3;
      metric0 = 14'(v);
      pulse_1hz;
      cyc(16);
      checks++; if (mode !== 2'd0) begin errs++; $display("FAIL hold_mode t%0d: got %0d want 0", t, mode); end
      scan4(exp_disp(v), 1'b1, $sformatf("hold_%0d", t));
    end
  endtask

  task automatic test_back_to_back;
    hold = 1'b1;
    metric0 = 14'd4321;
    pulse_1hz;
    cyc(5);
    metric0 = 14'd8765;
    pulse_1hz;
    cyc(10);
    checks++; if (busy !== 1'b0) begin errs++; $display("FAIL b2b_idle_gap: got busy=%b want 0", busy); end
    cyc(1);
    checks++; if (busy !== 1'b1) begin errs++; $display("FAIL b2b_restart: got busy=%b want 1", busy); end
    scan4(exp_disp(4321), 1'b1, "b2b_first");
    cyc(11);
    checks++; if (busy !== 1'b1) begin errs++; $display("FAIL b2b_commit: got busy=%b want 1", busy); end
    cyc(1);
    checks++; if (busy !== 1'b0) begin errs++; $display("FAIL b2b_done: got busy=%b want 0", busy); end
    scan4(exp_disp(8765), 1'b1, "b2b_second");
  endtask

  task automatic test_reset_mid;
    hold = 1'b0;
    for (int t = 0; t < 3; t++) begin
      pulse_1hz;
      cyc(19);
    end
    checks++; if (mode !== 2'd1) begin errs++; $display("FAIL mid_pre_mode: got %0d want 1", mode); end
    pulse_1hz;
    cyc(5);
    checks++; if (busy !== 1'b1) begin errs++; $display("FAIL mid_pre_busy: got %b want 1", busy); end
    rst = 1'b1;
    cyc(1);
    checks++; if (busy !== 1'b0) begin errs++; $display("FAIL mid_busy: got %b want 0", busy); end
    checks++; if (an !== 4'b1111) begin errs++; $display("FAIL mid_an: got %b want 1111", an); end
    checks++; if (mode !== 2'd0) begin errs++; $display("FAIL mid_mode: got %0d want 0", mode); end
    checks++; if (bcd_digit !== 4'hF) begin errs++; $display("FAIL mid_bcd: got %h want f", bcd_digit); end
    rst = 1'b0;
    cyc(20);
  endtask

  initial begin
    test_reset;
    test_first_conversion;
    test_blank_clamp;
    test_rotation;
    test_hold;
    test_back_to_back;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errs);
    $finish;
  end
endmodule
